// File: rtl/l15_data_arb_pkg.sv
// Shared types and width helpers for the L1.5 data RAM arbiter.
package l15_data_arb_pkg;

    localparam int unsigned NB_READERS_DEF   = 4;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    // A single reader still gets a 1-bit index so that vectors never collapse to zero width.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

    localparam int unsigned READER_IDX_W = idx_width(NB_READERS_DEF);
    localparam int unsigned STARVE_CNT_W = cnt_width(STARVE_LIMIT_DEF);

    typedef logic [READER_IDX_W-1:0] reader_idx_t;

endpackage

// File: rtl/l15_rr_pick.sv
// Combinational round-robin picker: the first requester at or after ptr wins.
module l15_rr_pick #(
    parameter int unsigned NB_READERS = 4,
    parameter int unsigned IDX_W      = 2
) (
    input  logic [NB_READERS-1:0] req,
    input  logic [IDX_W-1:0]      ptr,
    output logic [NB_READERS-1:0] gnt,
    output logic [IDX_W-1:0]      idx,
    output logic                  valid
);

    logic [31:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NB_READERS; i++) begin
            cand = (32'(ptr) + i) % NB_READERS;
            if (!valid && req[cand[IDX_W-1:0]]) begin
                valid                 = 1'b1;
                idx                   = cand[IDX_W-1:0];
                gnt[cand[IDX_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l15_data_ram_arbiter.sv
// Shares the single-port L1.5 data RAM between one refill writer and NB_READERS fetch readers.
module l15_data_ram_arbiter
    import l15_data_arb_pkg::*;
#(
    parameter int unsigned NB_READERS   = 4,
    parameter int unsigned DATA_WIDTH   = 128,
    parameter int unsigned ADDR_WIDTH   = 7,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_req_i,
    output logic                             wr_gnt_o,
    input  logic [ADDR_WIDTH-1:0]            wr_addr_i,
    input  logic [DATA_WIDTH-1:0]            wr_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]          wr_be_i,
    input  logic [NB_READERS-1:0]            rd_req_i,
    output logic [NB_READERS-1:0]            rd_gnt_o,
    input  logic [NB_READERS*ADDR_WIDTH-1:0] rd_addr_i,
    output logic [NB_READERS-1:0]            rd_rvalid_o,
    output logic [DATA_WIDTH-1:0]            rd_rdata_o,
    output logic                             ram_req_o,
    output logic                             ram_write_o,
    output logic [ADDR_WIDTH-1:0]            ram_addr_o,
    output logic [DATA_WIDTH-1:0]            ram_wdata_o,
    output logic [DATA_WIDTH/8-1:0]          ram_be_o,
    input  logic [DATA_WIDTH-1:0]            ram_rdata_i
);

    localparam int unsigned IDX_W = idx_width(NB_READERS);
    localparam int unsigned CNT_W = cnt_width(STARVE_LIMIT);

    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      rr_idx;
    logic [IDX_W-1:0]      rr_ptr_next;
    logic [NB_READERS-1:0] rr_gnt;
    logic                  rr_valid;
    logic [CNT_W-1:0]      starve_cnt;
    logic [NB_READERS-1:0] resp_onehot;
    logic                  rd_pending;
    logic                  wr_win;
    logic                  rd_win;
    logic [ADDR_WIDTH-1:0] rd_addr_sel;

    l15_rr_pick #(
        .NB_READERS (NB_READERS),
        .IDX_W      (IDX_W)
    ) u_rr_pick (
        .req   (rd_req_i),
        .ptr   (rr_ptr),
        .gnt   (rr_gnt),
        .idx   (rr_idx),
        .valid (rr_valid)
    );

    always_comb begin
        rd_pending  = |rd_req_i;
        // With no read waiting the write always wins; otherwise only until the budget runs out.
        wr_win      = wr_req_i && (!rd_pending || (starve_cnt < CNT_W'(STARVE_LIMIT)));
        rd_win      = !rst && !wr_win && rr_valid;
        wr_gnt_o    = !rst && wr_win;
        rd_gnt_o    = rd_win ? rr_gnt : '0;
        rd_addr_sel = rd_addr_i[rr_idx*ADDR_WIDTH +: ADDR_WIDTH];
        rr_ptr_next = (rr_idx == IDX_W'(NB_READERS - 1)) ? '0 : rr_idx + 1'b1;

        ram_req_o   = wr_gnt_o || rd_win;
        ram_write_o = wr_gnt_o;
        ram_addr_o  = wr_gnt_o ? wr_addr_i : rd_addr_sel;
        ram_wdata_o = wr_wdata_i;
        ram_be_o    = wr_gnt_o ? wr_be_i : '0;

        // A reset in the response cycle drops the in-flight line.
        rd_rvalid_o = rst ? '0 : resp_onehot;
        rd_rdata_o  = ram_rdata_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_onehot <= '0;
            rr_ptr      <= '0;
            starve_cnt  <= '0;
        end else begin
            resp_onehot <= rd_gnt_o;
            if (rd_win) begin
                rr_ptr <= rr_ptr_next;
            end
            if (rd_win || !rd_pending) begin
                starve_cnt <= '0;
            end else if (wr_gnt_o && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule
